decompress_controller: RTL and testbench
========================================

DECOMPRESS_CONTROLLER -- requirements
Module: decompress_controller

Interface
REQ-001 Parameter SRC_AW, default 16, source (compressed) RAM address width.
REQ-002 Parameter TIMEOUT, default 1023, max cycles to wait for handler done before error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; accepted only in IDLE.
REQ-006 src_base  in  SRC_AW  address of first compressed byte (in1 of pair 0).
REQ-007 pair_cnt  in  16  number of (in1,in2) pairs to decompress; 0 legal.
REQ-008 dst_byte  in  32  initial output byte index.
REQ-009 mem_rd  out  1  read strobe to source RAM, held until mem_valid.
REQ-010 mem_addr  out  SRC_AW  source read address.
REQ-011 mem_rdata  in  8  read data, valid when mem_valid=1.
REQ-012 mem_valid  in  1  read-complete strobe, one cycle.
REQ-013 hd_in1, hd_in2  out  8 each  compressed pair to decompress_handler.
REQ-014 hd_byte_idx  out  32; hd_bit_idx  out  3  current write position to handler.
REQ-015 hd_work  out  1  request handler to process current pair.
REQ-016 hd_done  in  1  handler completion level; hd_new_byte_idx  in  32; hd_new_bit_idx  in  3.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 finished  out  1  one-cycle pulse on normal completion.
REQ-019 error  out  1  sticky timeout flag, cleared by next accepted start.
REQ-020 pairs_done  out  16  count of pairs completed in current job.

Function
REQ-021 States: IDLE, RD1, RD2, ISSUE, WAIT, RELEASE, ADV, FIN.
REQ-022 IDLE: on start, latch src_base/pair_cnt/dst_byte, set byte_idx=dst_byte, bit_idx=7, pairs_done=0, error=0; go RD1, or FIN if pair_cnt=0.
REQ-023 RD1: mem_rd=1, mem_addr=src_ptr; on mem_valid latch hd_in1, src_ptr+1 (wraps mod 2^SRC_AW), go RD2.
REQ-024 RD2: same as RD1 but latches hd_in2, go ISSUE.
REQ-025 ISSUE: hd_work=1 for exactly one cycle, clear wait counter, go WAIT; hd_in1/in2/byte_idx/bit_idx held stable from ISSUE until leaving RELEASE.
REQ-026 WAIT: on hd_done=1 latch hd_new_byte_idx/hd_new_bit_idx, go RELEASE; else counter+1; counter=TIMEOUT sets error, go IDLE without finished.
REQ-027 RELEASE: wait for hd_done=0 (edge-based handler), then go ADV; no timeout here.
REQ-028 ADV: byte_idx/bit_idx <= latched new values, pairs_done+1; go RD1 if pairs_done+1<pair_cnt else FIN.
REQ-029 FIN: finished=1 one cycle, go IDLE.
REQ-030 start outside IDLE ignored; mem_valid outside RD1/RD2 ignored; hd_done outside WAIT/RELEASE ignored.
REQ-031 hd_done already high entering WAIT counts as done (level-sensitive).
REQ-032 mem_valid and timeout never coincide (no timeout in RD states; source RAM assumed to respond).
REQ-033 Minimum per-pair latency: 2 reads + 4 cycles (ISSUE, WAIT, RELEASE, ADV) with zero-latency handler.
REQ-034 byte_idx arithmetic is 32-bit unsigned, wrap silently; bit_idx 3-bit.

Reset
REQ-035 RST asserted at any time forces IDLE within zero cycles: mem_rd=0, hd_work=0, busy=0, finished=0, error=0, pairs_done=0, hd_in1=hd_in2=0, hd_byte_idx=0, hd_bit_idx=7, mem_addr=0.
REQ-036 Reset mid-job abandons the job; no finished pulse after release.

Structure
REQ-037 Shared package decomp_pkg holds state enum, BIT_IDX_INIT=7, default TIMEOUT.
REQ-038 One sub-module natural: decomp_wait_timer (loadable counter with terminal flag) used in WAIT.

Verification
REQ-039 pair_cnt=0, start -> busy for 1 cycle (FIN), finished pulse, no mem_rd, no hd_work.
REQ-040 src_base=0x10, pair_cnt=2, RAM {0x85,0xAA,0x03,0x0F}, handler model returns (dst+1,2) then (dst+2,7) -> hd_in1/in2 = 0x85/0xAA then 0x03/0x0F, final hd_byte_idx=dst+2, bit 7, pairs_done=2, one finished.
REQ-041 Handler never asserts hd_done, TIMEOUT=15 -> error=1 at 16th WAIT cycle, IDLE, no finished; next start clears error.
REQ-042 src_base=0xFFFF, pair_cnt=1 -> reads 0xFFFF then 0x0000.
REQ-043 RST asserted during WAIT of pair 2 of 3 -> outputs at reset values immediately, no finished, new start runs cleanly.
REQ-044 start pulsed during WAIT -> ignored; pairs_done and indices unaffected.

Source files
------------

// File: rtl/decomp_pkg.sv
// Shared types and constants for the decompression controller slice.
package decomp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    ISSUE,
    WAIT,
    RELEASE,
    ADV,
    FIN
  } ctrlState_t;

  localparam logic [2:0] BIT_IDX_INIT    = 3'd7;
  localparam int         DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/decomp_wait_timer.sv
// Clearable up-counter that saturates at LIMIT and flags the terminal count.
module decomp_wait_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic RST,
  input  logic clear,
  input  logic advance,
  output logic terminal
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CW'(LIMIT));

endmodule

// File: rtl/decompress_controller.sv
// Walks compressed byte pairs out of source RAM and hands each pair to an
// external decompress handler, tracking the running output byte/bit position.
module decompress_controller
  import decomp_pkg::*;
#(
  parameter int SRC_AW  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [15:0]       pair_cnt,
  input  logic [31:0]       dst_byte,
  output logic              mem_rd,
  output logic [SRC_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_valid,
  output logic [7:0]        hd_in1,
  output logic [7:0]        hd_in2,
  output logic [31:0]       hd_byte_idx,
  output logic [2:0]        hd_bit_idx,
  output logic              hd_work,
  input  logic              hd_done,
  input  logic [31:0]       hd_new_byte_idx,
  input  logic [2:0]        hd_new_bit_idx,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [15:0]       pairs_done
);

  ctrlState_t  state;
  logic [15:0] pairCnt;
  logic [31:0] newByteIdx;
  logic [2:0]  newBitIdx;
  logic        timerDone;
  logic        moreLeft;

  decomp_wait_timer #(
    .LIMIT(TIMEOUT)
  ) waitTimer (
    .clk     (clk),
    .RST     (RST),
    .clear   (state == ISSUE),
    .advance ((state == WAIT) && !hd_done),
    .terminal(timerDone)
  );

  assign moreLeft = ({1'b0, pairs_done} + 17'd1) < {1'b0, pairCnt};

  // Job parameters and handler results; only meaningful while a job is active.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      pairCnt <= pair_cnt;
    end
    if (state == WAIT && hd_done) begin
      newByteIdx <= hd_new_byte_idx;
      newBitIdx  <= hd_new_bit_idx;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      hd_in1      <= '0;
      hd_in2      <= '0;
      hd_byte_idx <= '0;
      hd_bit_idx  <= BIT_IDX_INIT;
      hd_work     <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      error       <= 1'b0;
      pairs_done  <= '0;
    end else begin
      hd_work  <= 1'b0;
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr    <= src_base;
            hd_byte_idx <= dst_byte;
            hd_bit_idx  <= BIT_IDX_INIT;
            pairs_done  <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            if (pair_cnt == 16'd0) begin
              finished <= 1'b1;
              state    <= FIN;
            end else begin
              mem_rd <= 1'b1;
              state  <= RD1;
            end
          end
        end
        RD1: begin
          if (mem_valid) begin
            hd_in1   <= mem_rdata;
            mem_addr <= mem_addr + 1'b1;
            state    <= RD2;
          end
        end
        // hd_work is raised here so it is high for exactly the ISSUE cycle.
        RD2: begin
          if (mem_valid) begin
            hd_in2   <= mem_rdata;
            mem_addr <= mem_addr + 1'b1;
            mem_rd   <= 1'b0;
            hd_work  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (hd_done) begin
            state <= RELEASE;
          end else if (timerDone) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (!hd_done) begin
            state <= ADV;
          end
        end
        ADV: begin
          hd_byte_idx <= newByteIdx;
          hd_bit_idx  <= newBitIdx;
          pairs_done  <= pairs_done + 1'b1;
          if (moreLeft) begin
            mem_rd <= 1'b1;
            state  <= RD1;
          end else begin
            finished <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompress_controller.sv
// Directed bench for decompress_controller with a source RAM and handler model.
module tb_decompress_controller;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] src_base;
  logic [15:0] pair_cnt;
  logic [31:0] dst_byte;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic [7:0]  hd_in1;
  logic [7:0]  hd_in2;
  logic [31:0] hd_byte_idx;
  logic [2:0]  hd_bit_idx;
  logic        hd_work;
  logic        hd_done;
  logic [31:0] hd_new_byte_idx;
  logic [2:0]  hd_new_bit_idx;
  logic        busy;
  logic        finished;
  logic        error;
  logic [15:0] pairs_done;

  always #5 clk = ~clk;

  decompress_controller #(
    .SRC_AW (16),
    .TIMEOUT(15)
  ) dut (
    .clk            (clk),
    .RST            (RST),
    .start          (start),
    .src_base       (src_base),
    .pair_cnt       (pair_cnt),
    .dst_byte       (dst_byte),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_valid      (mem_valid),
    .hd_in1         (hd_in1),
    .hd_in2         (hd_in2),
    .hd_byte_idx    (hd_byte_idx),
    .hd_bit_idx     (hd_bit_idx),
    .hd_work        (hd_work),
    .hd_done        (hd_done),
    .hd_new_byte_idx(hd_new_byte_idx),
    .hd_new_bit_idx (hd_new_bit_idx),
    .busy           (busy),
    .finished       (finished),
    .error          (error),
    .pairs_done     (pairs_done)
  );

  // Source RAM: one-cycle response strobe per outstanding read.
  logic [7:0] ram [0:65535];

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      mem_valid <= 1'b0;
      mem_rdata <= 8'h00;
    end else if (mem_rd && !mem_valid) begin
      mem_valid <= 1'b1;
      mem_rdata <= ram[mem_addr];
    end else begin
      mem_valid <= 1'b0;
    end
  end

  // Handler: after hdLat cycles returns (byte+1, bit 7->2 else 7), done held 2 cycles.
  int          hdLat;
  bit          hdEnable;
  int          hdPhase;
  int          hdCnt;
  logic [31:0] hdByte;
  logic [2:0]  hdBit;

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      hdPhase         <= 0;
      hdCnt           <= 0;
      hd_done         <= 1'b0;
      hd_new_byte_idx <= 32'h0;
      hd_new_bit_idx  <= 3'd0;
    end else begin
      case (hdPhase)
        0: begin
          if (hd_work && hdEnable) begin
            hdPhase <= 1;
            hdCnt   <= hdLat;
            hdByte  <= hd_byte_idx + 32'd1;
            hdBit   <= (hd_bit_idx == 3'd7) ? 3'd2 : 3'd7;
          end
        end
        1: begin
          if (hdCnt == 0) begin
            hd_done         <= 1'b1;
            hd_new_byte_idx <= hdByte;
            hd_new_bit_idx  <= hdBit;
            hdPhase         <= 2;
            hdCnt           <= 1;
          end else begin
            hdCnt <= hdCnt - 1;
          end
        end
        default: begin
          if (hdCnt == 0) begin
            hd_done <= 1'b0;
            hdPhase <= 0;
          end else begin
            hdCnt <= hdCnt - 1;
          end
        end
      endcase
    end
  end

  int          finCnt, busyCnt, rdCnt, workCnt, addrCnt;
  logic [15:0] addrLog [0:7];
  logic [7:0]  in1Log  [0:7];
  logic [7:0]  in2Log  [0:7];
  logic [31:0] byteLog [0:7];
  logic [2:0]  bitLog  [0:7];

  always @(negedge clk) begin
    if (finished) finCnt++;
    if (busy) busyCnt++;
    if (mem_rd) rdCnt++;
    if (mem_rd && mem_valid) begin
      if (addrCnt < 8) addrLog[addrCnt[2:0]] = mem_addr;
      addrCnt++;
    end
    if (hd_work) begin
      if (workCnt < 8) begin
        in1Log[workCnt[2:0]]  = hd_in1;
        in2Log[workCnt[2:0]]  = hd_in2;
        byteLog[workCnt[2:0]] = hd_byte_idx;
        bitLog[workCnt[2:0]]  = hd_bit_idx;
      end
      workCnt++;
    end
  end

  int total;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    finCnt  = 0;
    busyCnt = 0;
    rdCnt   = 0;
    workCnt = 0;
    addrCnt = 0;
  endtask

  task automatic pulseStart(input logic [15:0] src, input logic [15:0] cnt, input logic [31:0] dst);
    @(negedge clk);
    src_base = src;
    pair_cnt = cnt;
    dst_byte = dst;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitFinished(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (finished) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic waitWork(input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (hd_work) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    check({pfx, "_ctrl"}, 32'({busy, mem_rd, hd_work, finished, error}), 32'h0);
    check({pfx, "_pairs"}, 32'(pairs_done), 32'h0);
    check({pfx, "_byte"}, hd_byte_idx, 32'h0);
    check({pfx, "_bit"}, 32'(hd_bit_idx), 32'h7);
    check({pfx, "_in"}, 32'({hd_in1, hd_in2}), 32'h0);
    check({pfx, "_addr"}, 32'(mem_addr), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   n;
    total    = 0;
    fails    = 0;
    RST      = 1'b1;
    start    = 1'b0;
    src_base = 16'h0;
    pair_cnt = 16'h0;
    dst_byte = 32'h0;
    hdLat    = 1;
    hdEnable = 1'b1;
    clearMon();
    ram[16'h0010] = 8'h85;
    ram[16'h0011] = 8'hAA;
    ram[16'h0012] = 8'h03;
    ram[16'h0013] = 8'h0F;
    ram[16'hFFFF] = 8'h5A;
    ram[16'h0000] = 8'hC3;

    #12;
    checkResetOutputs("rst");
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-pair job: straight to FIN.
    clearMon();
    pulseStart(16'h0010, 16'd0, 32'h40);
    waitFinished(10, seen);
    check("zero_seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
    check("zero_fin", 32'(finCnt), 32'd1);
    check("zero_busy", 32'(busyCnt), 32'd1);
    check("zero_rd", 32'(rdCnt), 32'd0);
    check("zero_work", 32'(workCnt), 32'd0);

    // Two pairs from 0x10.
    hdLat = 1;
    clearMon();
    pulseStart(16'h0010, 16'd2, 32'h100);
    waitFinished(200, seen);
    check("two_seen", 32'(seen), 32'h1);
    check("two_pairs", 32'(pairs_done), 32'd2);
    check("two_byte", hd_byte_idx, 32'h102);
    check("two_bit", 32'(hd_bit_idx), 32'h7);
    @(negedge clk);
    check("two_busy", 32'(busy), 32'h0);
    check("two_fin", 32'(finCnt), 32'd1);
    check("two_work", 32'(workCnt), 32'd2);
    check("two_p0", 32'({in1Log[0], in2Log[0]}), 32'h85AA);
    check("two_p1", 32'({in1Log[1], in2Log[1]}), 32'h030F);
    check("two_pos0", byteLog[0], 32'h100);
    check("two_pos1", byteLog[1], 32'h101);
    check("two_bit1", 32'(bitLog[1]), 32'h2);
    check("two_addr01", {addrLog[0], addrLog[1]}, 32'h0010_0011);
    check("two_addr23", {addrLog[2], addrLog[3]}, 32'h0012_0013);
    check("two_err", 32'(error), 32'h0);

    // Handler never responds: error after 16 WAIT cycles.
    hdEnable = 1'b0;
    clearMon();
    pulseStart(16'h0010, 16'd1, 32'h300);
    waitWork(40, seen);
    check("to_work", 32'(seen), 32'h1);
    n = 0;
    while (!error && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'd17);
    check("to_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    check("to_sticky", 32'(error), 32'h1);
    check("to_nofin", 32'(finCnt), 32'd0);
    hdEnable = 1'b1;
    pulseStart(16'h0010, 16'd0, 32'h0);
    check("to_clear", 32'(error), 32'h0);
    repeat (3) @(negedge clk);

    // Address wrap at top of source space.
    clearMon();
    pulseStart(16'hFFFF, 16'd1, 32'hFFFF_FFFF);
    waitFinished(200, seen);
    check("wrap_seen", 32'(seen), 32'h1);
    check("wrap_addr", {addrLog[0], addrLog[1]}, 32'hFFFF_0000);
    check("wrap_data", 32'({in1Log[0], in2Log[0]}), 32'h5AC3);
    check("wrap_byte", hd_byte_idx, 32'h0);
    check("wrap_pairs", 32'(pairs_done), 32'd1);
    repeat (3) @(negedge clk);

    // Reset during WAIT of the second of three pairs.
    hdLat = 8;
    clearMon();
    pulseStart(16'h0010, 16'd3, 32'h500);
    waitWork(100, seen);
    @(negedge clk);
    waitWork(100, seen);
    check("mid_work2", 32'(seen), 32'h1);
    @(negedge clk);
    check("mid_pairs_pre", 32'(pairs_done), 32'd1);
    RST = 1'b1;
    #1;
    checkResetOutputs("mid");
    @(negedge clk);
    RST = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_nofin", 32'(finCnt), 32'd0);
    check("mid_idle", 32'(busy), 32'h0);
    hdLat = 1;
    clearMon();
    pulseStart(16'h0012, 16'd1, 32'h600);
    waitFinished(200, seen);
    check("mid_rerun_seen", 32'(seen), 32'h1);
    check("mid_rerun_data", 32'({in1Log[0], in2Log[0]}), 32'h030F);
    check("mid_rerun_byte", hd_byte_idx, 32'h601);
    check("mid_rerun_pairs", 32'(pairs_done), 32'd1);
    repeat (3) @(negedge clk);

    // Start pulse during WAIT must be ignored.
    hdLat = 8;
    clearMon();
    pulseStart(16'h0010, 16'd2, 32'h200);
    waitWork(100, seen);
    @(negedge clk);
    pulseStart(16'h0040, 16'd0, 32'h999);
    check("ign_pairs", 32'(pairs_done), 32'd0);
    check("ign_byte", hd_byte_idx, 32'h200);
    waitFinished(300, seen);
    check("ign_seen", 32'(seen), 32'h1);
    check("ign_pairs_end", 32'(pairs_done), 32'd2);
    check("ign_byte_end", hd_byte_idx, 32'h202);
    check("ign_bit_end", 32'(hd_bit_idx), 32'h7);
    check("ign_p1", 32'({in1Log[1], in2Log[1]}), 32'h030F);
    @(negedge clk);
    check("ign_fin", 32'(finCnt), 32'd1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
